// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the execute
// stage load/store port (master 0) and the instruction-fetch port (master 1).
// Master 0 has fixed priority; a starvation counter forces a master-1 grant
// after STARVE_MAX consecutive denied cycles. Read data is routed back to
// its owner one cycle after the grant.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  // master 0: execute-stage load/store
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wen,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  // master 1: instruction fetch (read only)
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  // RAM port
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  // pipeline control
  output logic                hold_flag_o
);

  localparam int          BE_W       = DATA_W / 8;
  localparam logic [2:0]  STARVE_LIM = 3'(STARVE_MAX);

  // read tracking and starvation state
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;
  logic [2:0] starve_q, starve_d;

  // combinational arbitration intermediates
  logic              m1_force_s;
  logic [ADDR_W-1:0] sel_addr_s;

  // Arbitration, RAM port muxing and next-state computation.
  always_comb begin
    m1_force_s = m1_req & (starve_q == STARVE_LIM);
    m0_gnt     = m0_req & ~m1_force_s;
    m1_gnt     = m1_force_s | (m1_req & ~m0_req);

    ram_en     = 1'b0;
    ram_we     = {BE_W{1'b0}};
    sel_addr_s = {ADDR_W{1'b0}};
    ram_wdata  = {DATA_W{1'b0}};
    if (m0_gnt) begin
      ram_en     = 1'b1;
      ram_we     = m0_we ? m0_wen : {BE_W{1'b0}};
      sel_addr_s = m0_addr;
      ram_wdata  = m0_we ? m0_wdata : {DATA_W{1'b0}};
    end else if (m1_gnt) begin
      ram_en     = 1'b1;
      sel_addr_s = m1_addr;
    end else begin
      ram_en     = 1'b0;
    end
    // word-align the address presented to the RAM
    ram_addr = sel_addr_s & ~{{(ADDR_W-2){1'b0}}, 2'b11};

    // a read is tracked only for load or fetch grants; stores complete now
    rd_pend_d  = (m0_gnt & ~m0_we) | m1_gnt;
    rd_owner_d = rd_owner_q;
    if (m1_gnt) begin
      rd_owner_d = 1'b1;
    end else if (m0_gnt & ~m0_we) begin
      rd_owner_d = 1'b0;
    end else begin
      rd_owner_d = rd_owner_q;
    end

    // count consecutive denied fetch cycles, saturating at the limit
    starve_d = 3'd0;
    if (m1_req & ~m1_gnt) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 3'd1;
    end else begin
      starve_d = 3'd0;
    end

    hold_flag_o = (m0_req & ~m0_gnt) | (m0_req & ~m0_we & m0_gnt);
  end

  // Read data return routing from the tracked owner.
  always_comb begin
    m0_rvalid = rd_pend_q & ~rd_owner_q;
    m1_rvalid = rd_pend_q & rd_owner_q;
    m0_rdata  = m0_rvalid ? ram_rdata : {DATA_W{1'b0}};
    m1_rdata  = m1_rvalid ? ram_rdata : {DATA_W{1'b0}};
  end

  // State registers; reset drops any pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      starve_q   <= 3'd0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      starve_q   <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_wen;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic        hold_flag_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wen(m0_wen), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .hold_flag_o(hold_flag_o)
  );

  // behavioural single-port synchronous RAM with byte enables
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[9:2]];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wen = 4'h0;
    m1_req = 1'b0; m1_addr = 32'h0;
  endtask

  task automatic test_reset();
    logic [140:0] obs;
    rst = 1'b1;
    drive_idle();
    next_cycle(); next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      obs = {m0_gnt, m1_gnt, ram_en, ram_we, ram_addr, ram_wdata, m0_rvalid, m1_rvalid,
             m0_rdata, m1_rdata, hold_flag_o};
      n_cmp++;
      if (obs !== 141'h0) begin
        n_err++;
        $display("FAIL idle_outputs cycle %0d: got %h want 0", i, obs);
      end
      next_cycle();
    end
    // reset asserted in the same cycle a read is granted: no rvalid after
    m1_req = 1'b1; m1_addr = 32'h10; rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (m1_gnt !== 1'b1) begin
      n_err++; $display("FAIL rst_read_gnt: got %b want 1", m1_gnt);
    end
    next_cycle();
    m1_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m1_rvalid, m0_rvalid, m1_rdata} !== 34'h0) begin
      n_err++; $display("FAIL rst_drop_read: got rv=%b/%b rdata=%h want 0", m1_rvalid, m0_rvalid, m1_rdata);
    end
    next_cycle();
  endtask

  task automatic test_load();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0104;
    @(negedge clk);
    n_cmp++;
    if ({m0_gnt, m1_gnt, ram_en, ram_we, ram_addr, hold_flag_o} !== {3'b101, 4'h0, 32'h104, 1'b1}) begin
      n_err++;
      $display("FAIL load_grant: got gnt=%b/%b en=%b we=%h addr=%h hold=%b want 1/0 1 0 104 1",
               m0_gnt, m1_gnt, ram_en, ram_we, ram_addr, hold_flag_o);
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, hold_flag_o} !== {2'b10, 32'hDEAD_BEEF, 1'b0}) begin
      n_err++;
      $display("FAIL load_data: got rv=%b/%b rdata=%h hold=%b want 1/0 deadbeef 0",
               m0_rvalid, m1_rvalid, m0_rdata, hold_flag_o);
    end
    next_cycle();
  endtask

  task automatic test_store();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0002; m0_wen = 4'b0100; m0_wdata = 32'h00AB_0000;
    @(negedge clk);
    n_cmp++;
    if ({m0_gnt, ram_en, ram_we, ram_addr, ram_wdata, hold_flag_o} !==
        {2'b11, 4'b0100, 32'h0, 32'h00AB_0000, 1'b0}) begin
      n_err++;
      $display("FAIL store_grant: got gnt=%b en=%b we=%b addr=%h wdata=%h hold=%b want 1 1 0100 0 00ab0000 0",
               m0_gnt, ram_en, ram_we, ram_addr, ram_wdata, hold_flag_o);
    end
    next_cycle();
    // read the word back; no rvalid is owed for the store itself
    m0_we = 1'b0; m0_addr = 32'h0; m0_wen = 4'h0; m0_wdata = 32'h0;
    @(negedge clk);
    n_cmp++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      n_err++; $display("FAIL store_no_rvalid: got %b/%b want 0/0", m0_rvalid, m1_rvalid);
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hFFAB_FFFF}) begin
      n_err++; $display("FAIL store_readback: got rv=%b rdata=%h want 1 ffabffff", m0_rvalid, m0_rdata);
    end
    next_cycle();
  endtask

  task automatic test_m1_only();
    m1_req = 1'b1; m1_addr = 32'h13;
    @(negedge clk);
    n_cmp++;
    if ({m1_gnt, m0_gnt, ram_we, ram_addr, hold_flag_o} !== {2'b10, 4'h0, 32'h10, 1'b0}) begin
      n_err++;
      $display("FAIL m1_alone: got gnt=%b/%b we=%h addr=%h hold=%b want 1/0 0 10 0",
               m1_gnt, m0_gnt, ram_we, ram_addr, hold_flag_o);
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if ({m1_rvalid, m0_rvalid, m1_rdata} !== {2'b10, 32'h1111_0010}) begin
      n_err++; $display("FAIL m1_alone_data: got rv=%b/%b rdata=%h want 1/0 11110010", m1_rvalid, m0_rvalid, m1_rdata);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic exp_m1, exp_hold, exp_m0rv, exp_m1rv;
    logic prev_m0rd, prev_m1rd;
    prev_m0rd = 1'b0; prev_m1rd = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h10;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h30; m0_wdata = 32'h3333_3333; m0_wen = 4'hF;
    for (int c = 0; c < 10; c++) begin
      exp_m1   = (c == 4) || (c == 9);
      exp_hold = exp_m1 ? 1'b1 : ~m0_we;
      exp_m0rv = prev_m0rd;
      exp_m1rv = prev_m1rd;
      @(negedge clk);
      n_cmp++;
      if ({m0_gnt, m1_gnt, hold_flag_o} !== {~exp_m1, exp_m1, exp_hold}) begin
        n_err++;
        $display("FAIL starve_arb cycle %0d: got gnt=%b/%b hold=%b want %b/%b %b",
                 c, m0_gnt, m1_gnt, hold_flag_o, ~exp_m1, exp_m1, exp_hold);
      end
      n_cmp++;
      if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !==
          {exp_m0rv, exp_m1rv, (exp_m0rv ? 32'h3333_3333 : 32'h0), (exp_m1rv ? 32'h1111_0010 : 32'h0)}) begin
        n_err++;
        $display("FAIL starve_rdata cycle %0d: got rv=%b/%b rdata=%h/%h want rv=%b/%b",
                 c, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, exp_m0rv, exp_m1rv);
      end
      prev_m0rd = ~exp_m1 & ~m0_we;
      prev_m1rd = exp_m1;
      next_cycle();
      if (!exp_m1) m0_we = ~m0_we;
    end
    drive_idle();
    next_cycle();
  endtask

  task automatic test_pipelined();
    m1_req = 1'b1; m1_addr = 32'h10;
    @(negedge clk);
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      n_err++; $display("FAIL pipe_m1_gnt: got %b/%b want 1/0", m1_gnt, m0_gnt);
    end
    next_cycle();
    m1_req = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
    @(negedge clk);
    n_cmp++;
    if ({m0_gnt, m1_rvalid, m0_rvalid, m1_rdata, m0_rdata} !== {3'b110, 32'h1111_0010, 32'h0}) begin
      n_err++;
      $display("FAIL pipe_n1: got gnt0=%b rv=%b/%b rdata=%h/%h want 1 1/0 11110010/0",
               m0_gnt, m1_rvalid, m0_rvalid, m1_rdata, m0_rdata);
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== {2'b10, 32'h2222_0020, 32'h0}) begin
      n_err++;
      $display("FAIL pipe_n2: got rv=%b/%b rdata=%h/%h want 1/0 22220020/0",
               m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h1234_5678; m0_wen = 4'hF;
    @(negedge clk);
    n_cmp++;
    if ({m0_gnt, ram_we, hold_flag_o} !== {1'b1, 4'hF, 1'b0}) begin
      n_err++; $display("FAIL b2b_store: got gnt=%b we=%h hold=%b want 1 f 0", m0_gnt, ram_we, hold_flag_o);
    end
    next_cycle();
    m0_we = 1'b0; m0_wen = 4'h0; m0_wdata = 32'h0;
    @(negedge clk);
    n_cmp++;
    if ({m0_gnt, hold_flag_o, m0_rvalid} !== 3'b110) begin
      n_err++; $display("FAIL b2b_load: got gnt=%b hold=%b rv=%b want 1 1 0", m0_gnt, hold_flag_o, m0_rvalid);
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h1234_5678}) begin
      n_err++; $display("FAIL b2b_data: got rv=%b rdata=%h want 1 12345678", m0_rvalid, m0_rdata);
    end
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
    mem[65] = 32'hDEAD_BEEF;   // 0x104
    mem[4]  = 32'h1111_0010;   // 0x10
    mem[8]  = 32'h2222_0020;   // 0x20
    mem[12] = 32'h3333_3333;   // 0x30
    mem[16] = 32'h0000_0000;   // 0x40
    drive_idle();
    rst = 1'b1;
    #1;
    test_reset();
    test_load();
    test_store();
    test_m1_only();
    test_starvation();
    test_pipelined();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous data RAM between the execute stage's load/store port (master 0) and the instruction-fetch port (master 1). Each cycle it issues at most one RAM access and routes the read data back to its owner one cycle later. It raises a hold request to the pipeline controller while the execute stage is waiting for memory. Master 0 has fixed priority, with a starvation guard that guarantees master 1 progress.

## Interface
- ADDR_W, 32, byte-address width of both masters and the RAM port
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_MAX, 4, consecutive denied master-1 cycles after which master 1 takes priority (1..7)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- m0_req  in  1  execute-stage access request; held stable with its attributes until m0_gnt
- m0_we  in  1  1 = store, 0 = load
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  DATA_W  store data, already lane-aligned
- m0_wen  in  DATA_W/8  store byte enables (0001/0010/0100/1000/0011/1100/1111)
- m0_gnt  out  1  access issued to RAM this cycle
- m0_rvalid  out  1  load data valid on m0_rdata
- m0_rdata  out  DATA_W  load data
- m1_req  in  1  fetch read request; held stable until m1_gnt
- m1_addr  in  ADDR_W  fetch byte address
- m1_gnt  out  1  fetch issued to RAM this cycle
- m1_rvalid  out  1  fetch data valid
- m1_rdata  out  DATA_W  fetch data
- ram_en  out  1  RAM access strobe
- ram_we  out  DATA_W/8  byte write enables; all-zero = read
- ram_addr  out  ADDR_W  selected address with bits [1:0] forced to 0
- ram_wdata  out  DATA_W  selected write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read strobe
- hold_flag_o  out  1  stall request to pipeline control

## Operation
- Arbitration is combinational within the cycle:
  - If m1_req and starve_cnt == STARVE_MAX, master 1 is granted.
  - Else if m0_req, master 0 is granted.
  - Else if m1_req, master 1 is granted.
  - Exactly one gnt or none.
- A grant drives ram_en=1, ram_addr, ram_wdata, and ram_we from the granted master:
  - m0 store: ram_we = m0_wen. m0 load and m1 read: ram_we = 0.
  - No grant: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Read tracking registers: rd_pend (1 bit), rd_owner (1 bit).
  - Set on the edge after a read grant: rd_pend=1, rd_owner = granted master.
  - Otherwise rd_pend=0.
- mX_rvalid = rd_pend & (rd_owner == X).
  - mX_rdata = ram_rdata when mX_rvalid, else 0.
- Stores complete at grant: no rvalid, and rd_pend is cleared if no read is granted.
- starve_cnt (3 bits):
  - +1 on each cycle with m1_req & ~m1_gnt, saturating at STARVE_MAX.
  - Cleared on m1_gnt or ~m1_req.
- hold_flag_o = (m0_req & ~m0_gnt) | (m0_req & ~m0_we & m0_gnt).
  - The execute stage stalls until its load data returns.
  - A store that is granted immediately causes no hold.

## Timing
- Reset values: rd_pend=0, rd_owner=0, starve_cnt=0.
  - Hence m0_rvalid=m1_rvalid=0 and rdata=0.
  - gnt/ram_* follow the combinational rules, i.e. 0 with no requests.
- Read latency: grant in cycle N, rvalid/rdata in cycle N+1. Fixed; no wait states.
- Back-to-back accesses are pipelined. A new grant in cycle N+1 is legal while the cycle-N read data is returned.
  - Sustained throughput: one access per cycle.
- Simultaneous m0_req and m1_req with starve_cnt < STARVE_MAX: m0 wins and starve_cnt increments.
- Master 1 is granted no later than STARVE_MAX+1 cycles after m1_req rises.
- Store in cycle N followed by a load to the same address in N+1 returns the new data. This relies on RAM write-first ordering across cycles; the arbiter adds no forwarding.
- Reset asserted while a read is pending: rd_pend clears on that edge. No rvalid is produced for the dropped read.
- A request deasserted before grant is a protocol violation. Behaviour is undefined, but the arbiter must not lock up: all state recovers within one cycle.

## Test plan
- Reset, then idle: all outputs 0, ram_en=0 for 10 cycles. Assert rst mid-read: no rvalid the following cycle.
- m0 load at 0x0000_0104, RAM word 0xDEAD_BEEF:
  - cycle N: m0_gnt=1, ram_addr=0x104, ram_we=0, hold_flag_o=1.
  - cycle N+1: m0_rvalid=1, m0_rdata=0xDEAD_BEEF.
- m0 store, addr 0x0000_0002, wen=0100, wdata=0x00AB_0000: same-cycle m0_gnt=1, ram_we=0100, ram_addr=0x0, hold_flag_o=0, no rvalid.
- Both request continuously, m0 alternating loads/stores, STARVE_MAX=4:
  - m0 is granted 4 cycles.
  - m1 is granted in the 5th cycle and m0 sees hold_flag_o=1 that cycle.
  - starve_cnt returns to 0.
- Pipelined reads: m1 read 0x10 at N, m0 read 0x20 at N+1:
  - m1_rvalid at N+1 with RAM[0x10].
  - m0_rvalid at N+2 with RAM[0x20].
  - No cross-routing.
- Store 0x1234_5678 to 0x40 at N, m0 load 0x40 at N+1: m0_rdata=0x1234_5678 at N+2.
